// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access : MIPS memory-access pipeline stage (between execute and writeback)
//
// Takes the effective address, ALU op and store data from execute. It runs a
// request/acknowledge transaction on the data-RAM port, aligns and
// sign-extends loaded bytes, and produces the registered writeback record.
// While a RAM transaction is outstanding it raises a combinational stall
// request to the pipeline controller.
//
// Handshake: ram_req_o rises on the edge that enters WAIT and stays high, with
// ram_addr_o/ram_we_o/ram_be_o/ram_wdata_o held stable, until the edge that
// follows the single cycle in which ram_ack_i is high (ram_rdata_i is valid in
// that cycle), or until the timeout edge. ram_ack_i outside WAIT is ignored.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   op_i          ALU op from execute (LB/LW/SB/SW are the memory ops)
//   addr_i        effective byte address
//   sdata_i       store data (rt)
//   wreg_i        writeback record from execute
//   wreg_o        registered writeback record to writeback
//   stallreq_o    stall request (combinational)
//   err_o         one-cycle pulse on misaligned access or timeout
//   ram_*         data-RAM request port
// -----------------------------------------------------------------------------
package mem_access_pkg;

    typedef enum logic [3:0] {
        NOP_OP, ADD_OP, SUB_OP, AND_OP, OR_OP, XOR_OP, SLT_OP, LUI_OP,
        LB_OP, LW_OP, SB_OP, SW_OP
    } alu_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } reg_t;

endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  alu_t        op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] sdata_i,
    input  reg_t        wreg_i,
    output reg_t        wreg_o,
    output logic        stallreq_o,
    output logic        err_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_ack_i,
    input  logic [31:0] ram_rdata_i
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    alu_t        op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    reg_t        wreg_q, wreg_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        stall;

    logic        is_mem;
    logic        is_word;
    logic        is_store;
    logic        misaligned;
    logic [7:0]  rbyte;
    logic        last_wait;

    assign is_mem     = (op_i == LB_OP) || (op_i == LW_OP) ||
                        (op_i == SB_OP) || (op_i == SW_OP);
    assign is_word    = (op_i == LW_OP) || (op_i == SW_OP);
    assign is_store   = (op_i == SB_OP) || (op_i == SW_OP);
    assign misaligned = is_word && (addr_i[1:0] != 2'b00);

    // Byte lane selected by the latched low address bits.
    assign rbyte      = ram_rdata_i[{lane_q, 3'b000} +: 8];
    assign last_wait  = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        lane_d  = lane_q;
        wreg_d  = wreg_q;
        err_d   = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        stall   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!is_mem) begin
                    wreg_d = wreg_i;
                end else if (misaligned) begin
                    wreg_d    = wreg_i;
                    wreg_d.en = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    stall   = 1'b1;
                    state_d = WAIT;
                    op_d    = op_i;
                    lane_d  = addr_i[1:0];
                    cnt_d   = 8'd0;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {addr_i[31:2], 2'b00};
                    // No writeback is presented while the access is in flight.
                    wreg_d  = '0;
                    if (op_i == SB_OP) begin
                        be_d    = 4'b0001 << addr_i[1:0];
                        wdata_d = {4{sdata_i[7:0]}};
                    end else begin
                        be_d    = 4'b1111;
                        wdata_d = sdata_i;
                    end
                end
            end

            WAIT: begin
                // Ack takes priority over the timeout in the same cycle.
                if (ram_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    wreg_d  = wreg_i;
                    if (op_q == LW_OP) begin
                        wreg_d.data = ram_rdata_i;
                    end else if (op_q == LB_OP) begin
                        wreg_d.data = {{24{rbyte[7]}}, rbyte};
                    end
                end else if (last_wait) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    err_d     = 1'b1;
                    wreg_d.en = 1'b0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            op_q    <= NOP_OP;
            lane_q  <= 2'b00;
            wreg_q  <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            lane_q  <= lane_d;
            wreg_q  <= wreg_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Stall is suppressed in the reset cycle whatever op_i shows.
    assign stallreq_o  = stall && !rst;
    assign wreg_o      = wreg_q;
    assign err_o       = err_q;
    assign ram_req_o   = req_q;
    assign ram_we_o    = we_q;
    assign ram_addr_o  = addr_q;
    assign ram_be_o    = be_q;
    assign ram_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access : self-checking bench for mem_access (TIMEOUT = 4).
// Directed vector table, hand sequences for reset / reset-in-WAIT /
// back-to-back, then random transactions checked against a reference model.
// -----------------------------------------------------------------------------
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    alu_t        op_i;
    logic [31:0] addr_i;
    logic [31:0] sdata_i;
    reg_t        wreg_i;
    reg_t        wreg_o;
    logic        stallreq_o;
    logic        err_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_wdata_o;
    logic        ram_ack_i;
    logic [31:0] ram_rdata_i;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .op_i(op_i), .addr_i(addr_i), .sdata_i(sdata_i),
        .wreg_i(wreg_i), .wreg_o(wreg_o), .stallreq_o(stallreq_o), .err_o(err_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_ack_i(ram_ack_i),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        alu_t        op;
        logic [31:0] addr;
        logic [31:0] sdata;
        reg_t        wreg;
        int          n_ack;
        logic [31:0] rdata;
        reg_t        exp_wreg;
        logic        exp_err;
        int          exp_stall;
        int          exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic        chk_wdata;
        logic [31:0] exp_wdata;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic reg_t rt(input logic en, input logic [4:0] a, input logic [31:0] d);
        reg_t r;
        r.en = en; r.addr = a; r.data = d;
        return r;
    endfunction

    function automatic vec_t mk(input alu_t op, input logic [31:0] addr, input logic [31:0] sdata,
                                input reg_t w, input int n, input logic [31:0] rdata,
                                input reg_t ew, input logic eerr, input int estall, input int ereq,
                                input logic [31:0] eaddr, input logic [3:0] ebe, input logic ewe,
                                input logic chk, input logic [31:0] ewd);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.wreg = w; v.n_ack = n; v.rdata = rdata;
        v.exp_wreg = ew; v.exp_err = eerr; v.exp_stall = estall; v.exp_req = ereq;
        v.exp_addr = eaddr; v.exp_be = ebe; v.exp_we = ewe; v.chk_wdata = chk; v.exp_wdata = ewd;
        return v;
    endfunction

    // Reference model: derives the visible outcome of one transaction
    // directly from the access rules with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   r = v;
        int     lane = int'(v.addr[1:0]);
        bit     mem = (v.op == LB_OP) || (v.op == LW_OP) || (v.op == SB_OP) || (v.op == SW_OP);
        bit     word = (v.op == LW_OP) || (v.op == SW_OP);
        logic [31:0] b;
        r.exp_wreg = v.wreg; r.exp_err = 1'b0; r.exp_stall = 0; r.exp_req = 0;
        r.exp_addr = 32'd0; r.exp_be = 4'd0; r.exp_we = 1'b0; r.chk_wdata = 1'b0; r.exp_wdata = 32'd0;
        if (!mem) return r;
        if (word && lane != 0) begin
            r.exp_err = 1'b1; r.exp_wreg.en = 1'b0;
            return r;
        end
        r.exp_addr = v.addr - 32'(lane);
        r.exp_we   = (v.op == SB_OP) || (v.op == SW_OP);
        r.exp_be   = (v.op == SB_OP) ? 4'(1 << lane) : 4'hF;
        r.chk_wdata = r.exp_we;
        r.exp_wdata = (v.op == SB_OP) ? 32'(v.sdata[7:0]) * 32'h01010101 : v.sdata;
        if (v.n_ack >= TO) begin
            r.exp_req = TO; r.exp_stall = TO; r.exp_err = 1'b1; r.exp_wreg.en = 1'b0;
        end else begin
            r.exp_req = v.n_ack + 1; r.exp_stall = v.n_ack + 1;
            if (v.op == LW_OP) r.exp_wreg.data = v.rdata;
            if (v.op == LB_OP) begin
                b = (v.rdata >> (8 * lane)) & 32'hFF;
                r.exp_wreg.data = (b >= 32'd128) ? b - 32'd256 : b;
            end
        end
        return r;
    endfunction

    // Apply one transaction starting just after a rising edge; ends just
    // after a rising edge. The RAM responder acks in WAIT cycle n_ack.
    task automatic run_txn(input vec_t v, input bit tail_idle, input string tag);
        int   stall_cnt = 0;
        int   req_cnt = 0;
        int   err_cnt = 0;
        bit   done = 0;
        reg_t idle_w;
        op_i = v.op; addr_i = v.addr; sdata_i = v.sdata; wreg_i = v.wreg; ram_ack_i = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (ram_req_o) begin
                if (req_cnt == 0) begin
                    check({tag, " ram_addr"}, ram_addr_o, v.exp_addr);
                    check({tag, " ram_be"}, 32'(ram_be_o), 32'(v.exp_be));
                    check({tag, " ram_we"}, 32'(ram_we_o), 32'(v.exp_we));
                    if (v.chk_wdata) check({tag, " ram_wdata"}, ram_wdata_o, v.exp_wdata);
                end
                ram_ack_i   = (req_cnt == v.n_ack);
                ram_rdata_i = ram_ack_i ? v.rdata : $urandom();
                req_cnt++;
            end
            #1;
            if (stallreq_o) stall_cnt++;
            @(posedge clk);
            #1;
            ram_ack_i = 1'b0;
            if (err_o) err_cnt++;
            if ((v.exp_req == 0 && c == 0) || (req_cnt > 0 && !ram_req_o)) done = 1;
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " wreg.en"}, 32'(wreg_o.en), 32'(v.exp_wreg.en));
        if (!v.exp_err) begin
            check({tag, " wreg.addr"}, 32'(wreg_o.addr), 32'(v.exp_wreg.addr));
            check({tag, " wreg.data"}, wreg_o.data, v.exp_wreg.data);
        end
        check({tag, " err_o"}, 32'(err_o), 32'(v.exp_err));
        check({tag, " stall cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
        check({tag, " req cycles"}, 32'(req_cnt), 32'(v.exp_req));
        if (tail_idle) begin
            // Idle NOP cycle with a stray ack that must be ignored.
            idle_w = rt(1'b1, 5'($urandom_range(0, 31)), $urandom());
            op_i = ADD_OP; wreg_i = idle_w; ram_ack_i = 1'b1; ram_rdata_i = $urandom();
            @(negedge clk);
            #1;
            check({tag, " idle stall"}, 32'(stallreq_o), 32'd0);
            @(posedge clk);
            #1;
            ram_ack_i = 1'b0;
            if (err_o) err_cnt++;
            check({tag, " idle ram_req"}, 32'(ram_req_o), 32'd0);
            check({tag, " idle wreg.data"}, wreg_o.data, idle_w.data);
            check({tag, " err pulses"}, 32'(err_cnt), 32'(v.exp_err));
        end
    endtask

    vec_t tbl[11];
    vec_t rv;
    alu_t ops[6] = '{ADD_OP, OR_OP, LB_OP, LW_OP, SB_OP, SW_OP};

    initial begin
        // Directed vectors with hand-derived expectations (TIMEOUT = 4).
        tbl[0]  = mk(ADD_OP, 32'h0, 32'h0, rt(1, 5, 32'h1234), 0, 32'h0,
                     rt(1, 5, 32'h1234), 0, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0);
        tbl[1]  = mk(LW_OP, 32'h100, 32'h0, rt(1, 3, 32'h0), 3, 32'hCAFEBABE,
                     rt(1, 3, 32'hCAFEBABE), 0, 4, 4, 32'h100, 4'hF, 0, 0, 32'h0);
        tbl[2]  = mk(LB_OP, 32'h103, 32'h0, rt(1, 4, 32'h0), 1, 32'h80000000,
                     rt(1, 4, 32'hFFFFFF80), 0, 2, 2, 32'h100, 4'hF, 0, 0, 32'h0);
        tbl[3]  = mk(LB_OP, 32'h101, 32'h0, rt(1, 6, 32'h0), 2, 32'h00007F00,
                     rt(1, 6, 32'h0000007F), 0, 3, 3, 32'h100, 4'hF, 0, 0, 32'h0);
        tbl[4]  = mk(SB_OP, 32'h202, 32'h000000AB, rt(0, 0, 32'h55), 1, 32'h0,
                     rt(0, 0, 32'h55), 0, 2, 2, 32'h200, 4'b0100, 1, 1, 32'hABABABAB);
        tbl[5]  = mk(SW_OP, 32'h206, 32'h11111111, rt(1, 9, 32'h77), 1, 32'h0,
                     rt(0, 9, 32'h77), 1, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0);
        tbl[6]  = mk(LW_OP, 32'h104, 32'h0, rt(1, 2, 32'h0), 9, 32'h0,
                     rt(0, 2, 32'h0), 1, 4, 4, 32'h104, 4'hF, 0, 0, 32'h0);
        tbl[7]  = mk(SW_OP, 32'h300, 32'h12345678, rt(1, 0, 32'hAA), 1, 32'h0,
                     rt(1, 0, 32'hAA), 0, 2, 2, 32'h300, 4'hF, 1, 1, 32'h12345678);
        tbl[8]  = mk(LW_OP, 32'h101, 32'h0, rt(1, 1, 32'h1), 1, 32'h0,
                     rt(0, 1, 32'h1), 1, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0);
        tbl[9]  = mk(LB_OP, 32'h102, 32'h0, rt(1, 7, 32'h0), 3, 32'h00FF0000,
                     rt(1, 7, 32'hFFFFFFFF), 0, 4, 4, 32'h100, 4'hF, 0, 0, 32'h0);
        tbl[10] = mk(SB_OP, 32'h1F3, 32'h123456C3, rt(1, 8, 32'h9), 2, 32'h0,
                     rt(1, 8, 32'h9), 0, 3, 3, 32'h1F0, 4'b1000, 1, 1, 32'hC3C3C3C3);

        // Reset with a memory op presented: no stall, all outputs zero.
        rst = 1'b1; op_i = LW_OP; addr_i = 32'h100; sdata_i = 32'h0;
        wreg_i = rt(1, 1, 32'h1); ram_ack_i = 1'b0; ram_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", 32'(stallreq_o), 32'd0);
        check("reset wreg", wreg_o.data | 32'(wreg_o.addr) | 32'(wreg_o.en), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset req", 32'(ram_req_o), 32'd0);
        check("reset we", 32'(ram_we_o), 32'd0);
        check("reset addr", ram_addr_o, 32'd0);
        check("reset be", 32'(ram_be_o), 32'd0);
        check("reset wdata", ram_wdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_txn(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Reset asserted while in WAIT.
        op_i = LW_OP; addr_i = 32'h400; wreg_i = rt(1, 3, 32'h5);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rstwait req before", 32'(ram_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstwait stall", 32'(stallreq_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; op_i = ADD_OP; wreg_i = rt(0, 0, 32'h0);
        check("rstwait req", 32'(ram_req_o), 32'd0);
        check("rstwait wreg.en", 32'(wreg_o.en), 32'd0);
        check("rstwait err", 32'(err_o), 32'd0);
        check("rstwait addr", ram_addr_o, 32'd0);
        @(posedge clk);
        #1;
        check("rstwait err after", 32'(err_o), 32'd0);
        rv = mk(LW_OP, 32'h404, 32'h0, rt(1, 12, 32'h0), 2, 32'h0BADF00D,
                rt(1, 12, 32'h0BADF00D), 0, 3, 3, 32'h404, 4'hF, 0, 0, 32'h0);
        run_txn(rv, 1'b1, "after_rst");

        // Back-to-back memory ops with no idle cycle between them.
        rv = mk(LW_OP, 32'h500, 32'h0, rt(1, 10, 32'h0), 1, 32'h13572468,
                rt(1, 10, 32'h13572468), 0, 2, 2, 32'h500, 4'hF, 0, 0, 32'h0);
        run_txn(rv, 1'b0, "b2b_a");
        rv = mk(SB_OP, 32'h601, 32'h0000005A, rt(0, 0, 32'h0), 1, 32'h0,
                rt(0, 0, 32'h0), 0, 2, 2, 32'h600, 4'b0010, 1, 1, 32'h5A5A5A5A);
        run_txn(rv, 1'b1, "b2b_b");

        // Random transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            rv.op    = ops[$urandom_range(0, 5)];
            rv.addr  = $urandom();
            rv.sdata = $urandom();
            rv.wreg  = rt(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
            rv.n_ack = $urandom_range(1, 6);
            rv.rdata = $urandom();
            rv = model(rv);
            run_txn(rv, ($urandom_range(0, 1) == 1) || rv.exp_err, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage for the MIPS core. It sits between the execute stage and writeback, and consumes the execute stage's effective RAM address, ALU op and store data. It runs a request/acknowledge transaction on the data-RAM port, aligns and sign-extends loaded bytes, and produces the registered writeback record. While a RAM transaction is outstanding it raises a stall request to the pipeline controller.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles in WAIT without `ram_ack_i` before the access is aborted (8-bit counter, 1..255).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, synchronous, active-high
- op_i  in  alu_t  op from execute; only LB_OP, LW_OP, SB_OP and SW_OP are memory ops
- addr_i  in  32  effective byte address (execute's ram address output)
- sdata_i  in  32  store data (rt value)
- wreg_i  in  reg_t  writeback record from execute (en, addr, data)
- wreg_o  out  reg_t  registered writeback record to writeback stage
- stallreq_o  out  1  stall request to pipeline controller (combinational)
- err_o  out  1  one-cycle pulse: misaligned access or timeout
- ram_req_o  out  1  RAM request, held until ack
- ram_we_o  out  1  1 = write
- ram_addr_o  out  32  word address, {addr_i[31:2], 2'b00}
- ram_be_o  out  4  byte enables, bit n = byte lane n (little-endian)
- ram_wdata_o  out  32  write data
- ram_ack_i  in  1  RAM completion, one cycle
- ram_rdata_i  in  32  read data, valid while ram_ack_i is high

## Operation
- States: IDLE, WAIT.
- IDLE, non-memory op: wreg_o <= wreg_i at the next edge. No stall.
- IDLE, memory op, aligned (LB/SB any address; LW/SW with addr_i[1:0]==0):
  - stallreq_o = 1.
  - Next edge: latch op, address and lane; drive the RAM outputs; counter <= 0; go to WAIT.
- IDLE, LW/SW misaligned:
  - No RAM request, no stall.
  - Next edge: wreg_o.en <= 0, err_o <= 1.
- WAIT:
  - ram_req_o = 1; addr, we, be and wdata are held stable.
  - stallreq_o = !ram_ack_i.
  - Counter increments each cycle without ack.
- WAIT with ram_ack_i = 1, next edge:
  - ram_req_o <= 0; go to IDLE.
  - wreg_o.en/addr take wreg_i.
  - wreg_o.data:
    - LW: ram_rdata_i.
    - LB: sign-extended byte ram_rdata_i[8*lane+7 : 8*lane].
    - SB/SW: wreg_i.data.
- WAIT with counter == TIMEOUT-1 and no ack, next edge:
  - ram_req_o <= 0, err_o <= 1, wreg_o.en <= 0; go to IDLE.
  - stallreq_o is 0 in that final cycle.
- Store encoding:
  - SW: be = 4'b1111, wdata = sdata_i.
  - SB: be = 4'b0001 << addr_i[1:0], wdata = {4{sdata_i[7:0]}}.
  - Loads: be = 4'b1111, we = 0.
- ram_ack_i in IDLE is ignored. Ack and timeout in the same cycle: ack wins.
- Upstream holds op_i/addr_i/sdata_i/wreg_i stable while stallreq_o = 1.

## Timing
- Reset values: state IDLE, wreg_o = all zeros, err_o = 0, ram_req_o = 0, ram_we_o = 0, ram_addr_o = 0, ram_be_o = 0, ram_wdata_o = 0, counter = 0.
- stallreq_o is 0 in the reset cycle regardless of op_i.
- Reset in WAIT: ram_req_o low from the next cycle, no writeback, no err_o.
- Non-memory op: 1-cycle latency.
- Memory op with ack N cycles after entering WAIT (N ≥ 1): stall for N+1 cycles (IDLE cycle plus N WAIT cycles, ack cycle excluded); wreg_o valid at the edge ending the ack cycle.
- Back-to-back memory ops: the second op is seen in IDLE on the cycle after completion. There is no idle bubble beyond that IDLE cycle.
- err_o is high for exactly one cycle per fault.

## Test plan
- Non-memory op, wreg_i = {en 1, addr 5, data 0x1234}: wreg_o equals it 1 cycle later; stallreq_o never asserted.
- LW at 0x100, ack 3 cycles after request:
  - ram_addr_o = 0x100, be = 0xF, we = 0.
  - stallreq_o high for 4 cycles.
  - wreg_o.data = rdata 0xCAFEBABE.
- LB at 0x103, rdata 0x80000000: be = 0xF; wreg_o.data = 0xFFFFFF80. LB at 0x101, rdata 0x00007F00: wreg_o.data = 0x0000007F.
- SB at 0x202, sdata 0x000000AB: ram_addr_o = 0x200, be = 4'b0100, wdata = 0xABABABAB, we = 1. SW at 0x206: no request, err_o pulses, wreg_o.en = 0.
- Ack never arrives, TIMEOUT = 4: ram_req_o high for 4 cycles, then drops; err_o pulses; stallreq_o released. A late ack in IDLE has no effect.
- rst asserted during WAIT: all outputs reach reset values next cycle. The following LW completes normally.
